// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter for the single-port 128x32 packet RAM, with a bounded burst per owner.
// Optional macro ARB_LOCK_EN adds input a_lock, which holds A ownership past the burst limit.
module ram_port_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
`ifdef ARB_LOCK_EN
    input  logic              a_lock,
`endif
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic             last_b;
    logic             lock;
    logic             sel_b;
    logic             gnt_any;
    logic             hold;
    logic             other_req;
    logic [CNT_W-1:0] cur_cnt;

`ifdef ARB_LOCK_EN
    assign lock = a_lock;
`else
    assign lock = 1'b0;
`endif

    // An owner that stops requesting hands the slot straight to a waiting peer, so a
    // switch never costs an idle cycle.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        case (state)
            OWN_A: begin
                if (a_req)              a_gnt = 1'b1;
                else if (b_req && !lock) b_gnt = 1'b1;
            end
            OWN_B: begin
                if (b_req)      b_gnt = 1'b1;
                else if (a_req) a_gnt = 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt_any   = a_gnt | b_gnt;
    assign sel_b     = b_gnt | ((state == OWN_B) & ~a_gnt);
    assign other_req = b_gnt ? a_req : b_req;
    assign hold      = a_gnt & (state == OWN_A) & lock;
    // A handoff grant starts a fresh burst for the new owner.
    assign cur_cnt   = (b_gnt == (state == OWN_B)) ? burst_cnt : '0;

    assign ram_addr = sel_b ? b_addr : a_addr;
    assign ram_data = sel_b ? b_wdata : a_wdata;
    assign ram_we   = (a_gnt & a_we) | (b_gnt & b_we);

    assign a_rdata = ram_q;
    assign b_rdata = ram_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last_b    <= 1'b1;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            b_rvalid <= b_gnt & ~b_we;
            if (gnt_any) begin
                last_b <= b_gnt;
                if (cur_cnt == LAST && other_req && !hold) begin
                    state     <= b_gnt ? OWN_A : OWN_B;
                    burst_cnt <= '0;
                end else begin
                    state <= b_gnt ? OWN_B : OWN_A;
                    if (cur_cnt == LAST) burst_cnt <= hold ? LAST : '0;
                    else                 burst_cnt <= cur_cnt + 5'd1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        burst_cnt <= '0;
                        if (a_req && (!b_req || last_b)) state <= OWN_A;
                        else if (b_req)                  state <= OWN_B;
                    end
                    OWN_A: begin
                        if (!lock) begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
